// File: rtl/fir_decim_ctrl.sv
// fir_decim_ctrl: read-side sequencer for the polyphase decimator RAM bank.
// Writes each accepted sample into the circular sample RAM. Every D-th accept
// starts one MAC pass that pairs samples newest-to-oldest with coefficients 0..MAC_SIZE-1.
// Optional feature: define FIR_CTRL_OVERRUN_EN to add the ovr_clr/ovr_cnt dropped-sample counter.
module fir_decim_ctrl #(
    parameter int MAC_SIZE = 255,
    parameter int D        = 100,
    parameter int MAC_NUM  = 1,
    localparam int AW      = (MAC_SIZE > 1) ? $clog2(MAC_SIZE) : 1,
    localparam int PW      = (D > 1) ? $clog2(D) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
`ifdef FIR_CTRL_OVERRUN_EN
    input  logic          ovr_clr,
    output logic [7:0]    ovr_cnt,
`endif
    output logic          in_ready,
    output logic          sample_en,
    output logic          sample_we,
    output logic [AW-1:0] sample_addr,
    output logic          coeff_en,
    output logic [AW-1:0] coeff_addr,
    output logic          coeff_busy,
    output logic          mac_clr,
    output logic          mac_en,
    output logic          mac_last,
    output logic          out_valid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [AW-1:0] ADDR_LAST  = AW'(MAC_SIZE - 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(D - 1);

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] base;
    logic [AW-1:0] k;
    logic [PW-1:0] phase;
    logic [AW-1:0] rd_addr;
    logic [AW:0]   rd_wrapped;
    logic          accept;

    // State register; an async reset aborts any pass in flight.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Read address base-k modulo MAC_SIZE by compare and wrap (depth need not be a power of 2).
    always_comb begin
        rd_wrapped = {1'b0, base} + (AW+1)'(MAC_SIZE) - {1'b0, k};
        if (base >= k) begin
            rd_addr = base - k;
        end else begin
            rd_addr = rd_wrapped[AW-1:0];
        end
    end

    // Next-state and combinational strobes.
    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        in_ready    = 1'b0;
        sample_en   = 1'b0;
        sample_we   = 1'b0;
        sample_addr = '0;
        coeff_en    = 1'b0;
        coeff_addr  = '0;
        coeff_busy  = 1'b0;
        out_valid   = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid) begin
                    sample_en   = 1'b1;
                    sample_we   = 1'b1;
                    sample_addr = wr_ptr;
                    if (phase == PHASE_LAST) begin
                        state_next = S_CALC;
                    end
                end
            end
            S_CALC: begin
                sample_en   = 1'b1;
                sample_addr = rd_addr;
                coeff_en    = 1'b1;
                coeff_addr  = k;
                coeff_busy  = 1'b1;
                if (k == ADDR_LAST) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                coeff_busy = 1'b1;
                state_next = S_DONE;
            end
            S_DONE: begin
                coeff_busy = 1'b1;
                out_valid  = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Write pointer, pass base, decimation phase and tap counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            base   <= '0;
            phase  <= '0;
            k      <= '0;
        end else if (accept) begin
            base   <= wr_ptr;
            wr_ptr <= (wr_ptr == ADDR_LAST) ? '0 : wr_ptr + AW'(1);
            if (phase == PHASE_LAST) begin
                phase <= '0;
                k     <= '0;
            end else begin
                phase <= phase + PW'(1);
            end
        end else if (state == S_CALC && k != ADDR_LAST) begin
            k <= k + AW'(1);
        end
    end

    // MAC strobes trail the CALC addresses by the one-cycle RAM read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mac_en   <= 1'b0;
            mac_clr  <= 1'b0;
            mac_last <= 1'b0;
        end else begin
            mac_en   <= (state == S_CALC);
            mac_clr  <= (state == S_CALC) && (k == '0);
            mac_last <= (state == S_CALC) && (k == ADDR_LAST);
        end
    end

`ifdef FIR_CTRL_OVERRUN_EN
    // Saturating count of samples offered while busy; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_cnt <= '0;
        end else if (ovr_clr) begin
            ovr_cnt <= '0;
        end else if (in_valid && !in_ready && ovr_cnt != 8'hFF) begin
            ovr_cnt <= ovr_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fir_decim_ctrl.sv
// Self-checking bench for fir_decim_ctrl: a timing-rule reference model checked
// every cycle, directed literal checks, randomized traffic and a one-tap D=1 instance.
module tb_fir_decim_ctrl;

    localparam int M  = 8;
    localparam int DD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic       ovr_clr = 1'b0;
    logic       in_ready, sample_en, sample_we, coeff_en, coeff_busy;
    logic       mac_clr, mac_en, mac_last, out_valid;
    logic [2:0] sample_addr, coeff_addr;
    logic [7:0] ovr_cnt;

    logic       in_valid_1 = 1'b0;
    logic       in_ready_1, sample_en_1, sample_we_1, coeff_en_1, coeff_busy_1;
    logic       mac_clr_1, mac_en_1, mac_last_1, out_valid_1;
    logic [0:0] sample_addr_1, coeff_addr_1;
    logic [7:0] ovr_cnt_1;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    fir_decim_ctrl #(.MAC_SIZE(M), .D(DD), .MAC_NUM(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
`ifdef FIR_CTRL_OVERRUN_EN
        .ovr_clr(ovr_clr), .ovr_cnt(ovr_cnt),
`endif
        .in_ready(in_ready), .sample_en(sample_en), .sample_we(sample_we),
        .sample_addr(sample_addr), .coeff_en(coeff_en), .coeff_addr(coeff_addr),
        .coeff_busy(coeff_busy), .mac_clr(mac_clr), .mac_en(mac_en),
        .mac_last(mac_last), .out_valid(out_valid)
    );

    fir_decim_ctrl #(.MAC_SIZE(1), .D(1), .MAC_NUM(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_1),
`ifdef FIR_CTRL_OVERRUN_EN
        .ovr_clr(ovr_clr), .ovr_cnt(ovr_cnt_1),
`endif
        .in_ready(in_ready_1), .sample_en(sample_en_1), .sample_we(sample_we_1),
        .sample_addr(sample_addr_1), .coeff_en(coeff_en_1), .coeff_addr(coeff_addr_1),
        .coeff_busy(coeff_busy_1), .mac_clr(mac_clr_1), .mac_en(mac_en_1),
        .mac_last(mac_last_1), .out_valid(out_valid_1)
    );

`ifndef FIR_CTRL_OVERRUN_EN
    assign ovr_cnt   = 8'd0;
    assign ovr_cnt_1 = 8'd0;
`endif

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A pass is described only by the cycle of its completing accept (m_t0) and
    // its base; every output follows from the cycle offset to that accept.
    int cyc = 0;
    int m_wr = 0, m_phase = 0, m_base = 0, m_t0 = 0, m_ovr = 0;
    bit m_act = 1'b0;
    int m_rel;
    bit m_busy;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        m_rel  = cyc - m_t0;
        m_busy = m_act && (m_rel >= 1) && (m_rel <= M + 2);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_wr    <= 0;
            m_phase <= 0;
            m_act   <= 1'b0;
            m_ovr   <= 0;
        end else begin
            if (in_valid && !m_busy) begin
                m_wr <= (m_wr + 1) % M;
                if (m_phase == DD - 1) begin
                    m_phase <= 0;
                    m_act   <= 1'b1;
                    m_t0    <= cyc;
                    m_base  <= m_wr;
                end else begin
                    m_phase <= m_phase + 1;
                end
            end
            if (ovr_clr) m_ovr <= 0;
            else if (in_valid && m_busy && m_ovr < 255) m_ovr <= m_ovr + 1;
        end
    end

    // Compare process: every output, every cycle, against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            bit in_calc, exp_we;
            int exp_saddr;
            in_calc   = m_busy && (m_rel <= M);
            exp_we    = !m_busy && in_valid;
            exp_saddr = in_calc ? (((m_base - m_rel + 1) % M) + M) % M : (exp_we ? m_wr : 0);
            check("in_ready",    in_ready,    !m_busy);
            check("sample_we",   sample_we,   exp_we);
            check("sample_en",   sample_en,   exp_we || in_calc);
            check("sample_addr", sample_addr, exp_saddr);
            check("coeff_en",    coeff_en,    in_calc);
            check("coeff_addr",  coeff_addr,  in_calc ? m_rel - 1 : 0);
            check("coeff_busy",  coeff_busy,  m_busy);
            check("mac_en",      mac_en,      m_busy && m_rel >= 2 && m_rel <= M + 1);
            check("mac_clr",     mac_clr,     m_busy && m_rel == 2);
            check("mac_last",    mac_last,    m_busy && m_rel == M + 1);
            check("out_valid",   out_valid,   m_busy && m_rel == M + 2);
`ifdef FIR_CTRL_OVERRUN_EN
            check("ovr_cnt",     ovr_cnt,     m_ovr);
`endif
        end
    end

    // ---------------- stimulus and literal checks ----------------
    int rec_saddr[42], rec_caddr[42];
    bit rec_we[42], rec_ov[42], rec_clr[42], rec_last[42], rec_ready[42];
    int exp_rd[8] = '{3, 2, 1, 0, 7, 6, 5, 4};

    initial begin
        bit found;
        int ov_at;

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_in_ready",  in_ready, 1);
        check("rst_strobes",   {sample_en, sample_we, coeff_en, coeff_busy, mac_clr, mac_en, mac_last, out_valid}, 0);
        check("rst_addrs",     {sample_addr, coeff_addr}, 0);

        // Continuous in_valid: three full passes recorded, then pinned to literals
        @(posedge clk); #1 in_valid = 1'b1;
        for (int n = 0; n < 42; n++) begin
            @(negedge clk);
            rec_saddr[n] = sample_addr; rec_caddr[n] = coeff_addr; rec_we[n] = sample_we;
            rec_ov[n] = out_valid; rec_clr[n] = mac_clr; rec_last[n] = mac_last; rec_ready[n] = in_ready;
        end
        check("lit_first_we",   rec_we[0], 1);
        check("lit_first_addr", rec_saddr[0], 0);
        check("lit_acc4_addr",  rec_saddr[3], 3);
        for (int i = 0; i < 8; i++) begin
            check("lit_rd_addr",    rec_saddr[4 + i], exp_rd[i]);
            check("lit_coeff_addr", rec_caddr[4 + i], i);
        end
        for (int n = 4; n < 14; n++) check("lit_no_we_busy", rec_we[n], 0);
        check("lit_mac_clr",     rec_clr[5], 1);
        check("lit_mac_last",    rec_last[12], 1);
        check("lit_out_valid",   rec_ov[13], 1);
        check("lit_ready_back",  rec_ready[14], 1);
        check("lit_acc5_addr",   rec_saddr[14], 4);
        check("lit_pass2_base",  rec_saddr[18], 7);
        check("lit_wrap_addr",   rec_saddr[28], 0);
        check("lit_acc12_addr",  rec_saddr[31], 3);
        check("lit_pass3_base",  rec_saddr[32], 3);
        check("lit_pass3_wrap",  rec_saddr[36], 7);

        // Async reset during the third CALC cycle
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (coeff_en && coeff_addr == 3'd2) found = 1'b1;
        end
        check("calc3_reached", found, 1);
        #2 rst_n = 1'b0; in_valid = 1'b0;
        #1;
        check("abort_strobes", {sample_en, sample_we, coeff_en, coeff_busy, mac_clr, mac_en, mac_last, out_valid}, 0);
        check("abort_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1; in_valid = 1'b1;
        ov_at = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == 0) check("post_rst_addr", sample_addr, 0);
            if (out_valid && ov_at < 0) ov_at = i;
        end
        check("post_rst_out_at", ov_at, 13);

`ifdef FIR_CTRL_OVERRUN_EN
        @(posedge clk); #1 rst_n = 1'b0; in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1; in_valid = 1'b1;
        repeat (9) @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("ovr_five", ovr_cnt, 5);
        @(posedge clk); #1 ovr_clr = 1'b1;
        @(posedge clk); #1 ovr_clr = 1'b0;
        @(negedge clk);
        check("ovr_cleared", ovr_cnt, 0);
        in_valid = 1'b1;
        repeat (700) @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("ovr_saturated", ovr_cnt, 255);
`endif

        // Randomized traffic: dense then sparse, occasional counter clear
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            in_valid = (i < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0);
            ovr_clr  = ($urandom_range(0, 199) == 0);
        end
        @(posedge clk); #1 in_valid = 1'b0; ovr_clr = 1'b0;
        repeat (12) @(posedge clk);

        // MAC_SIZE=1, D=1: every accept is a single-tap pass
        #1 in_valid_1 = 1'b1;
        @(negedge clk);
        check("one_accept_we",   sample_we_1, 1);
        check("one_accept_addr", sample_addr_1, 0);
        @(negedge clk);
        check("one_calc",        {coeff_en_1, coeff_busy_1, sample_en_1, in_ready_1, sample_we_1}, 5'b11100);
        check("one_calc_addrs",  {sample_addr_1, coeff_addr_1}, 0);
        @(negedge clk);
        check("one_mac_all",     {mac_clr_1, mac_en_1, mac_last_1, out_valid_1}, 4'b1110);
        @(negedge clk);
        check("one_out_valid",   {out_valid_1, mac_en_1, coeff_busy_1}, 3'b101);
        @(negedge clk);
        check("one_ready_again", {in_ready_1, sample_we_1, sample_addr_1}, 3'b110);
        @(posedge clk); #1 in_valid_1 = 1'b0;
        repeat (4) @(posedge clk);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
